grom_io_display: RTL and testbench

Parametrised I/O display controller for the grom8 system: decodes CPU I/O-port writes (`ioreq` & `we`) into per-digit hex registers, a blank mask and an LED/control register. It drives a time-multiplexed bank of NUM_DIGITS seven-segment digits with dead-time and blink. It replaces the fixed two-digit display latch in the board top, sits between `grom_cpu` and the board pins, and optionally supports CPU readback of its registers.

---
 rtl/grom_io_display.sv | 220 ++++++++++++++++++++++
 tb/tb_grom_io_display.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/grom_io_display.sv
// grom_io_display
//
// I/O-mapped display controller for the grom8 system. Decodes CPU I/O-port
// writes into per-digit hex nibbles, a blank mask and an LED/control register.
// It drives a time-multiplexed bank of seven-segment digits. Each digit slot
// starts with one dead cycle, and the display supports blink.
//
// Port map (H = NUM_DIGITS/2), relative to PORT_BASE:
//   k (0..H-1) : digit pair, [3:0] -> digit 2k, [7:4] -> digit 2k+1
//   H          : blank mask, bit i blanks digit i
//   H+1        : control, bit0 = blink enable, [7:4] = LED value
//   other      : ignored
//
// Optional feature macro: GROM_IO_READBACK_EN
//   defined     : an I/O read (i_Ioreq & ~i_We) loads o_Data with the
//                 addressed register; o_Data holds between reads
//   not defined : o_Data tied to 8'h00
//
// Ports:
//   i_Clk       system clock, rising edge
//   i_Reset_n   asynchronous active-low reset
//   i_Addr      I/O port number
//   i_Data      CPU write data
//   i_We        CPU write enable
//   i_Ioreq     CPU I/O request
//   o_Data      readback data
//   o_Segment   segments A..G on bits 0..6, active-high
//   o_Digit_En  digit select, one-hot or zero, active-high
//   o_LED       LED outputs

module grom_io_display #(
    parameter int         NUM_DIGITS  = 4,
    parameter int         SCAN_DIV    = 1024,
    parameter int         BLINK_SCANS = 64,
    parameter logic [7:0] PORT_BASE   = 8'h00
) (
    input  logic                  i_Clk,
    input  logic                  i_Reset_n,
    input  logic [7:0]            i_Addr,
    input  logic [7:0]            i_Data,
    input  logic                  i_We,
    input  logic                  i_Ioreq,
    output logic [7:0]            o_Data,
    output logic [6:0]            o_Segment,
    output logic [NUM_DIGITS-1:0] o_Digit_En,
    output logic [3:0]            o_LED
);

    localparam int H     = NUM_DIGITS / 2;
    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam int DIV_W = $clog2(SCAN_DIV);
    // +1 keeps the width at least one bit when BLINK_SCANS == 1
    localparam int BLK_W = $clog2(BLINK_SCANS + 1);

    localparam logic [7:0]       OFS_MASK = 8'(H);
    localparam logic [7:0]       OFS_CTRL = 8'(H + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_SCANS - 1);

    // ------------------------------------------------------------------
    // Register file
    // ------------------------------------------------------------------
    logic                  wr_stb;
    logic [7:0]            ofs;
    logic [3:0]            digit_q [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] mask_q;
    logic [3:0]            led_q;
    logic                  blink_en_q;

    assign wr_stb = i_Ioreq & i_We;
    // Offset from the base port; all decode is done on the offset so the
    // block can be placed anywhere in the 8-bit I/O space.
    assign ofs    = i_Addr - PORT_BASE;

    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                digit_q[i] <= 4'h0;
            end
            mask_q     <= '0;
            led_q      <= 4'h0;
            blink_en_q <= 1'b0;
        end else if (wr_stb) begin
            for (int k = 0; k < H; k++) begin
                if (ofs == 8'(k)) begin
                    digit_q[2*k]   <= i_Data[3:0];
                    digit_q[2*k+1] <= i_Data[7:4];
                end
            end
            if (ofs == OFS_MASK) begin
                mask_q <= i_Data[NUM_DIGITS-1:0];
            end
            if (ofs == OFS_CTRL) begin
                led_q      <= i_Data[7:4];
                blink_en_q <= i_Data[0];
            end
        end
    end

    assign o_LED = led_q;

    // ------------------------------------------------------------------
    // Scan divider, digit index and blink phase
    // ------------------------------------------------------------------
    logic [DIV_W-1:0] div_q;
    logic [IDX_W-1:0] idx_q;
    logic [BLK_W-1:0] blk_cnt_q;
    logic             phase_q;

    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            div_q     <= '0;
            idx_q     <= '0;
            blk_cnt_q <= '0;
            phase_q   <= 1'b0;
        end else if (div_q == DIV_LAST) begin
            div_q <= '0;
            if (idx_q == IDX_LAST) begin
                idx_q <= '0;
                // Blink phase counts full scan rounds, independent of the
                // blink enable, so enabling blink never restarts the phase.
                if (blk_cnt_q == BLK_LAST) begin
                    blk_cnt_q <= '0;
                    phase_q   <= ~phase_q;
                end else begin
                    blk_cnt_q <= blk_cnt_q + 1'b1;
                end
            end else begin
                idx_q <= idx_q + 1'b1;
            end
        end else begin
            div_q <= div_q + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Output register
    // ------------------------------------------------------------------
    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0:    s = 7'h3F;
            4'h1:    s = 7'h06;
            4'h2:    s = 7'h5B;
            4'h3:    s = 7'h4F;
            4'h4:    s = 7'h66;
            4'h5:    s = 7'h6D;
            4'h6:    s = 7'h7D;
            4'h7:    s = 7'h07;
            4'h8:    s = 7'h7F;
            4'h9:    s = 7'h6F;
            4'hA:    s = 7'h77;
            4'hB:    s = 7'h7C;
            4'hC:    s = 7'h39;
            4'hD:    s = 7'h5E;
            4'hE:    s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    logic                  lit;
    logic [NUM_DIGITS-1:0] onehot;
    logic [3:0]            cur_nibble;

    // divider == 0 is the dead cycle that separates adjacent digit slots
    assign lit        = (div_q != '0) && !mask_q[idx_q] && !(blink_en_q && phase_q);
    assign onehot     = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx_q;
    assign cur_nibble = digit_q[idx_q];

    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            o_Digit_En <= '0;
            o_Segment  <= 7'h00;
        end else if (lit) begin
            o_Digit_En <= onehot;
            o_Segment  <= hex7(cur_nibble);
        end else begin
            o_Digit_En <= '0;
            o_Segment  <= 7'h00;
        end
    end

    // ------------------------------------------------------------------
    // Optional readback
    // ------------------------------------------------------------------
`ifdef GROM_IO_READBACK_EN
    logic       rd_stb;
    logic [7:0] rd_data;

    assign rd_stb = i_Ioreq & ~i_We;

    always_comb begin
        rd_data = 8'h00;
        for (int k = 0; k < H; k++) begin
            if (ofs == 8'(k)) begin
                rd_data = {digit_q[2*k+1], digit_q[2*k]};
            end
        end
        if (ofs == OFS_MASK) begin
            rd_data = 8'(mask_q);
        end
        if (ofs == OFS_CTRL) begin
            rd_data = {led_q, 3'b000, blink_en_q};
        end
    end

    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            o_Data <= 8'h00;
        end else if (rd_stb) begin
            o_Data <= rd_data;
        end
    end
`else
    assign o_Data = 8'h00;
`endif

endmodule

// File: tb/tb_grom_io_display.sv
module tb_grom_io_display;

    localparam int ND = 4;
    localparam int SD = 4;
    localparam int BS = 2;
`ifdef GROM_IO_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [7:0]    addr = 8'h00;
    logic [7:0]    wdata = 8'h00;
    logic          we = 1'b0;
    logic          ioreq = 1'b0;
    logic [7:0]    rdata;
    logic [6:0]    seg;
    logic [ND-1:0] den;
    logic [3:0]    led;

    grom_io_display #(
        .NUM_DIGITS (ND),
        .SCAN_DIV   (SD),
        .BLINK_SCANS(BS),
        .PORT_BASE  (8'h00)
    ) dut (
        .i_Clk     (clk),
        .i_Reset_n (rst_n),
        .i_Addr    (addr),
        .i_Data    (wdata),
        .i_We      (we),
        .i_Ioreq   (ioreq),
        .o_Data    (rdata),
        .o_Segment (seg),
        .o_Digit_En(den),
        .o_LED     (led)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [6:0] seg;
        logic [3:0] en;
        logic [3:0] led;
        logic [7:0] data;
    } exp_t;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
        logic       we;
        logic       ioreq;
        int         idle;
        logic [3:0] exp_led;
        logic [7:0] exp_rd;
    } vec_t;

    exp_t       sbq[$];
    logic [6:0] seg_tab[16];

    // reference state: edges since reset release plus shadow registers
    int         m_edges;
    logic [3:0] sh_digit[ND];
    logic [3:0] sh_mask;
    logic       sh_blink;
    logic [3:0] sh_led;
    logic [7:0] sh_data;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic clear_shadow();
        for (int i = 0; i < ND; i++) sh_digit[i] = 4'h0;
        sh_mask  = 4'h0;
        sh_blink = 1'b0;
        sh_led   = 4'h0;
        sh_data  = 8'h00;
        m_edges  = 0;
    endtask

    // One clock: drive bus, predict the outputs that follow the edge, compare.
    task automatic tick(input logic [7:0] a, input logic [7:0] d, input logic w, input logic io);
        exp_t       e;
        exp_t       got;
        int         dv, ix, ph;
        bit         on;
        logic [7:0] rd;
        addr  = a;
        wdata = d;
        we    = w;
        ioreq = io;
        dv = m_edges % SD;
        ix = (m_edges / SD) % ND;
        ph = ((m_edges / (SD * ND)) / BS) % 2;
        on = (dv != 0) && !sh_mask[ix] && !(sh_blink && (ph == 1));
        e.en  = on ? 4'(1 << ix) : 4'h0;
        e.seg = on ? seg_tab[sh_digit[ix]] : 7'h00;
        if (io && w) begin
            case (a)
                8'h00: begin sh_digit[0] = d[3:0]; sh_digit[1] = d[7:4]; end
                8'h01: begin sh_digit[2] = d[3:0]; sh_digit[3] = d[7:4]; end
                8'h02: sh_mask = d[3:0];
                8'h03: begin sh_led = d[7:4]; sh_blink = d[0]; end
                default: ;
            endcase
        end else if (io && !w) begin
            case (a)
                8'h00:   rd = {sh_digit[1], sh_digit[0]};
                8'h01:   rd = {sh_digit[3], sh_digit[2]};
                8'h02:   rd = {4'h0, sh_mask};
                8'h03:   rd = {sh_led, 3'b000, sh_blink};
                default: rd = 8'h00;
            endcase
            sh_data = RB ? rd : 8'h00;
        end
        e.led  = sh_led;
        e.data = sh_data;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        m_edges++;
        got = '{seg, den, led, rdata};
        e = sbq.pop_front();
        check("seg",  {25'd0, got.seg}, {25'd0, e.seg});
        check("en",   {28'd0, got.en},  {28'd0, e.en});
        check("led",  {28'd0, got.led}, {28'd0, e.led});
        check("data", {24'd0, got.data}, {24'd0, e.data});
    endtask

    vec_t vecs[15];
    bit   lit_seen;

    initial begin
        seg_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        //            addr   data   we    io    idle exp_led exp_rd
        vecs[0]  = '{8'h00, 8'h3A, 1'b1, 1'b1, 0,   4'h0, 8'h00};
        vecs[1]  = '{8'h01, 8'hF0, 1'b1, 1'b1, 64,  4'h0, 8'h00};
        vecs[2]  = '{8'h00, 8'h00, 1'b0, 1'b1, 1,   4'h0, 8'h3A};
        vecs[3]  = '{8'h02, 8'h05, 1'b1, 1'b1, 32,  4'h0, 8'h3A};
        vecs[4]  = '{8'h02, 8'h00, 1'b0, 1'b1, 1,   4'h0, 8'h05};
        vecs[5]  = '{8'h02, 8'h00, 1'b1, 1'b1, 2,   4'h0, 8'h05};
        vecs[6]  = '{8'h03, 8'hA1, 1'b1, 1'b1, 96,  4'hA, 8'h05};
        vecs[7]  = '{8'h03, 8'h00, 1'b0, 1'b1, 1,   4'hA, 8'hA1};
        vecs[8]  = '{8'h20, 8'hFF, 1'b1, 1'b1, 4,   4'hA, 8'hA1};
        vecs[9]  = '{8'h20, 8'h00, 1'b0, 1'b1, 1,   4'hA, 8'h00};
        vecs[10] = '{8'h00, 8'h55, 1'b1, 1'b0, 4,   4'hA, 8'h00};
        vecs[11] = '{8'h00, 8'h00, 1'b0, 1'b1, 1,   4'hA, 8'h3A};
        vecs[12] = '{8'h01, 8'h5C, 1'b1, 1'b1, 0,   4'hA, 8'h3A};
        vecs[13] = '{8'h01, 8'h00, 1'b0, 1'b1, 1,   4'hA, 8'h5C};
        vecs[14] = '{8'h03, 8'h30, 1'b1, 1'b1, 6,   4'h3, 8'h5C};

        clear_shadow();
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_seg",  {25'd0, seg},   32'h0);
        check("rst_en",   {28'd0, den},   32'h0);
        check("rst_led",  {28'd0, led},   32'h0);
        check("rst_data", {24'd0, rdata}, 32'h0);
        rst_n = 1'b1;

        for (int v = 0; v < 15; v++) begin
            tick(vecs[v].addr, vecs[v].data, vecs[v].we, vecs[v].ioreq);
            check("op_led",  {28'd0, led},   {28'd0, vecs[v].exp_led});
            check("op_data", {24'd0, rdata}, RB ? {24'd0, vecs[v].exp_rd} : 32'h0);
            for (int i = 0; i < vecs[v].idle; i++) tick(8'h00, 8'h00, 1'b0, 1'b0);
        end

        // reset in the middle of a lit slot
        lit_seen = 1'b0;
        for (int i = 0; i < 8 && !lit_seen; i++) begin
            tick(8'h00, 8'h00, 1'b0, 1'b0);
            if (den != '0) lit_seen = 1'b1;
        end
        check("lit_before_reset", {31'd0, lit_seen}, 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_seg",  {25'd0, seg},   32'h0);
        check("async_rst_en",   {28'd0, den},   32'h0);
        check("async_rst_led",  {28'd0, led},   32'h0);
        check("async_rst_data", {24'd0, rdata}, 32'h0);
        @(posedge clk);
        #1;
        check("held_rst_en", {28'd0, den}, 32'h0);
        rst_n = 1'b1;
        clear_shadow();
        tick(8'h00, 8'h00, 1'b0, 1'b0);
        check("rel_edge1_en", {28'd0, den}, 32'h0);
        tick(8'h00, 8'h00, 1'b0, 1'b0);
        check("rel_edge2_en",  {28'd0, den}, 32'h1);
        check("rel_edge2_seg", {25'd0, seg}, 32'h3F);
        for (int i = 0; i < 14; i++) tick(8'h00, 8'h00, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
